// File: rtl/cva6_gtlb_pkg.sv
// cva6_gtlb_pkg: shared types and helpers for the G-stage TLB.
//   gtlb_entry_t : one stored Sv39x4 leaf translation
//   LVL_*        : page-size encodings (4K / 2M / 1G)
//   level_mask() : GPPN compare mask for a page size (0 bits are ignored)
// Storage widths below set the entry layout; the cva6_gtlb width
// parameters default to them and must not exceed them.
package cva6_gtlb_pkg;

    localparam int unsigned VMID_W = 14;
    localparam int unsigned GPPN_W = 29;
    localparam int unsigned PPN_W  = 44;

    localparam logic [1:0] LVL_4K = 2'd0;
    localparam logic [1:0] LVL_2M = 2'd1;
    localparam logic [1:0] LVL_1G = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [VMID_W-1:0] vmid;
        logic [GPPN_W-1:0] gppn;
        logic [PPN_W-1:0]  ppn;
        logic [3:0]        perm;
        logic [1:0]        level;
    } gtlb_entry_t;

    function automatic logic [GPPN_W-1:0] level_mask(input logic [1:0] level);
        logic [GPPN_W-1:0] m;
        m = '1;
        case (level)
            LVL_2M:  m[8:0]  = '0;
            LVL_1G:  m[17:0] = '0;
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cva6_plru_tree.sv
// cva6_plru_tree: tree pseudo-LRU over NrEntries ways (NrEntries-1 bits).
//   clk_i, rst_i   : clock, synchronous active-high reset (all bits 0)
//   touch_valid_i  : two touch requests; slot 0 is applied before slot 1
//   touch_idx_i    : way touched by each request
//   victim_idx_o   : way the tree currently points at
// A node bit of 1 steers the victim walk to the upper half.
module cva6_plru_tree #(
    parameter int unsigned NrEntries = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [1:0]                           touch_valid_i,
    input  logic [1:0][$clog2(NrEntries)-1:0]    touch_idx_i,
    output logic [$clog2(NrEntries)-1:0]         victim_idx_o
);

    localparam int unsigned IdxW = $clog2(NrEntries);

    logic [NrEntries-2:0] tree_q, tree_d;

    // Heap layout: node n has children 2n+1 / 2n+2; at depth lvl the node
    // for a way is (2^lvl - 1) + (way >> (IdxW - lvl)).
    always_comb begin
        int node;
        node   = 0;
        tree_d = tree_q;
        for (int t = 0; t < 2; t++) begin
            if (touch_valid_i[t]) begin
                for (int lvl = 0; lvl < int'(IdxW); lvl++) begin
                    node = (1 << lvl) - 1 + int'(touch_idx_i[t] >> (IdxW - lvl));
                    tree_d[node] = ~touch_idx_i[t][int'(IdxW) - 1 - lvl];
                end
            end
        end
    end

    always_comb begin
        int vnode;
        vnode        = 0;
        victim_idx_o = '0;
        for (int lvl = 0; lvl < int'(IdxW); lvl++) begin
            victim_idx_o[int'(IdxW) - 1 - lvl] = tree_q[vnode];
            vnode = 2 * vnode + 1 + int'(tree_q[vnode]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule

// File: rtl/cva6_gtlb.sv
// cva6_gtlb: fully-associative G-stage TLB (GPPN -> host PPN), VMID tagged.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   lu_*_i / lu_*_o        : lookup request, registered response (1 cycle)
//   fill_*_i               : refill from the PTW (level 3 stored as 4K)
//   flush_*_i              : HFENCE.GVMA with optional VMID / GPPN filters
//   perf_hit_cnt_o,
//   perf_miss_cnt_o        : saturating counters, only with
//                            CVA6_GTLB_PERF_CNT_EN defined
module cva6_gtlb
    import cva6_gtlb_pkg::*;
#(
    parameter int unsigned NrEntries = 16,
    parameter int unsigned VmidWidth = VMID_W,
    parameter int unsigned GppnWidth = GPPN_W,
    parameter int unsigned PpnWidth  = PPN_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lu_valid_i,
    input  logic [GppnWidth-1:0] lu_gppn_i,
    input  logic [VmidWidth-1:0] lu_vmid_i,
    output logic                 lu_valid_o,
    output logic                 lu_hit_o,
    output logic [PpnWidth-1:0]  lu_ppn_o,
    output logic [3:0]           lu_perm_o,
    output logic [1:0]           lu_level_o,
    input  logic                 fill_valid_i,
    input  logic [GppnWidth-1:0] fill_gppn_i,
    input  logic [VmidWidth-1:0] fill_vmid_i,
    input  logic [PpnWidth-1:0]  fill_ppn_i,
    input  logic [3:0]           fill_perm_i,
    input  logic [1:0]           fill_level_i,
    input  logic                 flush_i,
    input  logic                 flush_vmid_en_i,
    input  logic [VmidWidth-1:0] flush_vmid_i,
    input  logic                 flush_gaddr_en_i,
    input  logic [GppnWidth-1:0] flush_gppn_i
`ifdef CVA6_GTLB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_hit_cnt_o,
    output logic [31:0]          perf_miss_cnt_o
`endif
);

    localparam int unsigned IdxW = $clog2(NrEntries);

    gtlb_entry_t          entries_q [NrEntries];
    logic [GppnWidth-1:0] ent_mask  [NrEntries];

    logic [NrEntries-1:0] lu_match, fill_match, flush_match, entry_free;
    logic                 lu_hit, lu_hit_eff, same_any, free_any, fill_we;
    logic [IdxW-1:0]      lu_idx, same_idx, free_idx, fill_idx, victim_idx;
    logic [1:0]           fill_level;
    logic [GppnWidth-1:0] fill_mask, hit_mask;
    logic [PpnWidth-1:0]  hit_ppn;

    logic                 lu_valid_q, lu_hit_q;
    logic [IdxW-1:0]      lu_idx_q;
    logic [PpnWidth-1:0]  lu_ppn_q;
    logic [3:0]           lu_perm_q;
    logic [1:0]           lu_level_q;

    assign fill_level = (fill_level_i == 2'd3) ? LVL_4K : fill_level_i;
    assign fill_mask  = GppnWidth'(level_mask(fill_level));
    assign fill_we    = fill_valid_i && !flush_i;
    assign lu_hit_eff = lu_valid_i && lu_hit && !flush_i;

    for (genvar g = 0; g < NrEntries; g++) begin : g_cmp
        logic [GppnWidth-1:0] ent_gppn;
        logic [VmidWidth-1:0] ent_vmid;
        assign ent_mask[g] = GppnWidth'(level_mask(entries_q[g].level));
        assign ent_gppn    = GppnWidth'(entries_q[g].gppn);
        assign ent_vmid    = VmidWidth'(entries_q[g].vmid);
        assign lu_match[g] = entries_q[g].valid && (ent_vmid == lu_vmid_i)
                             && (((ent_gppn ^ lu_gppn_i) & ent_mask[g]) == '0);
        // Refill target: same VMID, same page size, same tag under that size.
        assign fill_match[g] = entries_q[g].valid && (ent_vmid == fill_vmid_i)
                               && (entries_q[g].level == fill_level)
                               && (((ent_gppn ^ fill_gppn_i) & fill_mask) == '0);
        assign flush_match[g] = entries_q[g].valid
                                && (!flush_vmid_en_i || (ent_vmid == flush_vmid_i))
                                && (!flush_gaddr_en_i
                                    || (((ent_gppn ^ flush_gppn_i) & ent_mask[g]) == '0));
        assign entry_free[g] = !entries_q[g].valid;
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lu_hit   = 1'b0;
        lu_idx   = '0;
        same_any = 1'b0;
        same_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
            if (lu_match[i]) begin
                lu_hit = 1'b1;
                lu_idx = IdxW'(i);
            end
            if (fill_match[i]) begin
                same_any = 1'b1;
                same_idx = IdxW'(i);
            end
            if (entry_free[i]) begin
                free_any = 1'b1;
                free_idx = IdxW'(i);
            end
        end
    end

    assign fill_idx = same_any ? same_idx : (free_any ? free_idx : victim_idx);

    // Superpage: bits the entry's mask ignores come from the request GPPN.
    always_comb begin
        hit_mask      = ent_mask[lu_idx];
        hit_ppn       = PpnWidth'(entries_q[lu_idx].ppn);
        hit_ppn[17:0] = (hit_ppn[17:0] & hit_mask[17:0]) | (lu_gppn_i[17:0] & ~hit_mask[17:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NrEntries); i++) begin
                entries_q[i] <= '0;
            end
            lu_valid_q <= 1'b0;
            lu_hit_q   <= 1'b0;
            lu_idx_q   <= '0;
            lu_ppn_q   <= '0;
            lu_perm_q  <= '0;
            lu_level_q <= '0;
        end else begin
            lu_valid_q <= lu_valid_i;
            lu_hit_q   <= lu_hit_eff;
            lu_idx_q   <= lu_idx;
            if (lu_hit_eff) begin
                lu_ppn_q   <= hit_ppn;
                lu_perm_q  <= entries_q[lu_idx].perm;
                lu_level_q <= entries_q[lu_idx].level;
            end else begin
                lu_ppn_q   <= '0;
                lu_perm_q  <= '0;
                lu_level_q <= '0;
            end
            if (flush_i) begin
                for (int i = 0; i < int'(NrEntries); i++) begin
                    if (flush_match[i]) begin
                        entries_q[i].valid <= 1'b0;
                    end
                end
            end else if (fill_valid_i) begin
                entries_q[fill_idx] <= '{valid: 1'b1,
                                         vmid:  VMID_W'(fill_vmid_i),
                                         gppn:  GPPN_W'(fill_gppn_i),
                                         ppn:   PPN_W'(fill_ppn_i),
                                         perm:  fill_perm_i,
                                         level: fill_level};
            end
        end
    end

    // Slot 0 is the registered hit, slot 1 the fill, so the fill lands last.
    logic [1:0]           touch_valid;
    logic [1:0][IdxW-1:0] touch_idx;

    assign touch_valid = {fill_we, lu_valid_q && lu_hit_q};
    assign touch_idx   = {fill_idx, lu_idx_q};

    cva6_plru_tree #(
        .NrEntries (NrEntries)
    ) i_plru (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .touch_valid_i (touch_valid),
        .touch_idx_i   (touch_idx),
        .victim_idx_o  (victim_idx)
    );

    assign lu_valid_o = lu_valid_q;
    assign lu_hit_o   = lu_hit_q;
    assign lu_ppn_o   = lu_ppn_q;
    assign lu_perm_o  = lu_perm_q;
    assign lu_level_o = lu_level_q;

`ifdef CVA6_GTLB_PERF_CNT_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (lu_valid_q) begin
            if (lu_hit_q) begin
                if (perf_hit_q != '1) perf_hit_q <= perf_hit_q + 32'd1;
            end else begin
                if (perf_miss_q != '1) perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt_o  = perf_hit_q;
    assign perf_miss_cnt_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_cva6_gtlb.sv
// tb_cva6_gtlb: directed and randomized checks of cva6_gtlb against a
// behavioural model (entry table, page-size shifts, range-halving PLRU tree).
module tb_cva6_gtlb;

    localparam int N = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lu_valid_i;
    logic [28:0] lu_gppn_i;
    logic [13:0] lu_vmid_i;
    logic        lu_valid_o, lu_hit_o;
    logic [43:0] lu_ppn_o;
    logic [3:0]  lu_perm_o;
    logic [1:0]  lu_level_o;
    logic        fill_valid_i;
    logic [28:0] fill_gppn_i;
    logic [13:0] fill_vmid_i;
    logic [43:0] fill_ppn_i;
    logic [3:0]  fill_perm_i;
    logic [1:0]  fill_level_i;
    logic        flush_i, flush_vmid_en_i, flush_gaddr_en_i;
    logic [13:0] flush_vmid_i;
    logic [28:0] flush_gppn_i;
`ifdef CVA6_GTLB_PERF_CNT_EN
    logic [31:0] perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    cva6_gtlb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lu_valid_i(lu_valid_i), .lu_gppn_i(lu_gppn_i), .lu_vmid_i(lu_vmid_i),
        .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_ppn_o(lu_ppn_o),
        .lu_perm_o(lu_perm_o), .lu_level_o(lu_level_o),
        .fill_valid_i(fill_valid_i), .fill_gppn_i(fill_gppn_i), .fill_vmid_i(fill_vmid_i),
        .fill_ppn_i(fill_ppn_i), .fill_perm_i(fill_perm_i), .fill_level_i(fill_level_i),
        .flush_i(flush_i), .flush_vmid_en_i(flush_vmid_en_i), .flush_vmid_i(flush_vmid_i),
        .flush_gaddr_en_i(flush_gaddr_en_i), .flush_gppn_i(flush_gppn_i)
`ifdef CVA6_GTLB_PERF_CNT_EN
        , .perf_hit_cnt_o(perf_hit_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_valid [N];
    logic [13:0] m_vmid  [N];
    logic [28:0] m_gppn  [N];
    logic [43:0] m_ppn   [N];
    logic [3:0]  m_perm  [N];
    logic [1:0]  m_level [N];
    bit          m_tree  [N-1];
    bit          pend_hit, pend_resp;
    int          pend_idx;
    longint      m_phit, m_pmiss;

    logic        exp_valid, exp_hit;
    logic [43:0] exp_ppn;
    logic [3:0]  exp_perm;
    logic [1:0]  exp_level;

    function automatic int shamt(input logic [1:0] l);
        return (l == 2'd1) ? 9 : ((l == 2'd2) ? 18 : 0);
    endfunction

    function automatic int model_lookup(input logic [13:0] v, input logic [28:0] g);
        int sh;
        for (int i = 0; i < N; i++) begin
            sh = shamt(m_level[i]);
            if (m_valid[i] && m_vmid[i] == v && (m_gppn[i] >> sh) == (g >> sh)) return i;
        end
        return -1;
    endfunction

    function automatic int model_victim();
        int lo, hi, node, mid;
        lo = 0; hi = N; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[node]) begin lo = mid; node = 2 * node + 2; end
            else begin hi = mid; node = 2 * node + 1; end
        end
        return lo;
    endfunction

    task automatic model_touch(input int idx);
        int lo, hi, node, mid;
        lo = 0; hi = N; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (idx < mid) begin m_tree[node] = 1'b1; node = 2 * node + 1; hi = mid; end
            else begin m_tree[node] = 1'b0; node = 2 * node + 2; lo = mid; end
        end
    endtask

    function automatic int model_fill_slot(input logic [13:0] v, input logic [28:0] g,
                                           input logic [1:0] l);
        int sh;
        sh = shamt(l);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_vmid[i] == v && m_level[i] == l && (m_gppn[i] >> sh) == (g >> sh))
                return i;
        for (int i = 0; i < N; i++)
            if (!m_valid[i]) return i;
        return model_victim();
    endfunction

    task automatic idle();
        rst_i = 1'b0; lu_valid_i = 1'b0; fill_valid_i = 1'b0; flush_i = 1'b0;
        flush_vmid_en_i = 1'b0; flush_gaddr_en_i = 1'b0;
    endtask

    task automatic set_fill(input logic [13:0] v, input logic [28:0] g, input logic [43:0] p,
                            input logic [3:0] pm, input logic [1:0] l);
        fill_valid_i = 1'b1; fill_vmid_i = v; fill_gppn_i = g; fill_ppn_i = p;
        fill_perm_i = pm; fill_level_i = l;
    endtask

    task automatic set_lookup(input logic [13:0] v, input logic [28:0] g);
        lu_valid_i = 1'b1; lu_vmid_i = v; lu_gppn_i = g;
    endtask

    task automatic set_flush(input logic ve, input logic [13:0] v, input logic ge,
                             input logic [28:0] g);
        flush_i = 1'b1; flush_vmid_en_i = ve; flush_vmid_i = v;
        flush_gaddr_en_i = ge; flush_gppn_i = g;
    endtask

    // One clock: predict the response from pre-edge model state, advance the
    // model, then return inputs to idle with outputs settled.
    task automatic step();
        int hidx, fidx, sh;
        logic [1:0] fl;
        hidx = -1;
        exp_valid = 1'b0; exp_hit = 1'b0; exp_ppn = '0; exp_perm = '0; exp_level = '0;
        if (!rst_i && lu_valid_i) begin
            exp_valid = 1'b1;
            hidx = flush_i ? -1 : model_lookup(lu_vmid_i, lu_gppn_i);
            if (hidx >= 0) begin
                sh = shamt(m_level[hidx]);
                exp_hit   = 1'b1;
                exp_ppn   = ((m_ppn[hidx] >> sh) << sh) | (44'(lu_gppn_i) & ((44'd1 << sh) - 44'd1));
                exp_perm  = m_perm[hidx];
                exp_level = m_level[hidx];
            end
        end
        @(posedge clk_i);
        if (rst_i) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            for (int i = 0; i < N - 1; i++) m_tree[i] = 1'b0;
            pend_hit = 1'b0; pend_resp = 1'b0; pend_idx = 0; m_phit = 0; m_pmiss = 0;
        end else begin
            fl   = (fill_level_i == 2'd3) ? 2'd0 : fill_level_i;
            fidx = (fill_valid_i && !flush_i) ? model_fill_slot(fill_vmid_i, fill_gppn_i, fl) : -1;
            if (pend_hit) model_touch(pend_idx);
            if (pend_resp) begin
                if (pend_hit) begin if (m_phit < 64'hFFFF_FFFF) m_phit++; end
                else begin if (m_pmiss < 64'hFFFF_FFFF) m_pmiss++; end
            end
            if (flush_i) begin
                for (int i = 0; i < N; i++) begin
                    sh = shamt(m_level[i]);
                    if (m_valid[i] && (!flush_vmid_en_i || m_vmid[i] == flush_vmid_i)
                        && (!flush_gaddr_en_i || (m_gppn[i] >> sh) == (flush_gppn_i >> sh)))
                        m_valid[i] = 1'b0;
                end
            end else if (fidx >= 0) begin
                m_valid[fidx] = 1'b1; m_vmid[fidx] = fill_vmid_i; m_gppn[fidx] = fill_gppn_i;
                m_ppn[fidx] = fill_ppn_i; m_perm[fidx] = fill_perm_i; m_level[fidx] = fl;
                model_touch(fidx);
            end
            pend_hit = exp_hit; pend_idx = hidx; pend_resp = exp_valid;
        end
        #1;
        idle();
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; lu_valid_i = 1'b1; lu_vmid_i = '0; lu_gppn_i = '0;
        step();
        total++; if (lu_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", lu_valid_o); end
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", lu_hit_o); end
        total++; if ({lu_ppn_o, lu_perm_o, lu_level_o} !== '0)
            begin bad++; $display("FAIL reset_data: got %h/%h/%h want 0", lu_ppn_o, lu_perm_o, lu_level_o); end
    endtask

    task automatic test_basic();
        reset_dut();
        set_fill(14'd3, 29'h1000, 44'hABCDE, 4'b1011, 2'd0); step();
        set_lookup(14'd3, 29'h1000); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b1)
            begin bad++; $display("FAIL basic_hit: got v=%b h=%b want v=1 h=1", lu_valid_o, lu_hit_o); end
        total++; if (lu_ppn_o !== 44'hABCDE || lu_perm_o !== 4'b1011 || lu_level_o !== 2'd0)
            begin bad++; $display("FAIL basic_data: got %h/%h/%h want abcde/b/0", lu_ppn_o, lu_perm_o, lu_level_o); end
        set_lookup(14'd4, 29'h1000); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b0)
            begin bad++; $display("FAIL basic_vmid_miss: got v=%b h=%b want v=1 h=0", lu_valid_o, lu_hit_o); end
    endtask

    task automatic test_superpage();
        reset_dut();
        set_fill(14'd1, 29'h20000, 44'h40000, 4'b0001, 2'd1); step();
        set_lookup(14'd1, 29'h20123); step();
        total++; if (lu_hit_o !== 1'b1 || lu_ppn_o !== 44'h40123 || lu_level_o !== 2'd1)
            begin bad++; $display("FAIL sp_2m: got h=%b %h l=%0d want h=1 40123 l=1", lu_hit_o, lu_ppn_o, lu_level_o); end
        set_lookup(14'd1, 29'h20323); step();
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL sp_2m_out: got %b want 0", lu_hit_o); end
        set_fill(14'd1, 29'h0C0000, 44'hF00000, 4'b0101, 2'd2); step();
        set_lookup(14'd1, 29'h0C1234); step();
        total++; if (lu_hit_o !== 1'b1 || lu_ppn_o !== 44'hF01234 || lu_level_o !== 2'd2)
            begin bad++; $display("FAIL sp_1g: got h=%b %h l=%0d want h=1 f01234 l=2", lu_hit_o, lu_ppn_o, lu_level_o); end
        set_fill(14'd1, 29'h5000, 44'h777, 4'b0011, 2'd3); step();
        set_lookup(14'd1, 29'h5001); step();
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL lvl3_as_4k_miss: got %b want 0", lu_hit_o); end
        set_lookup(14'd1, 29'h5000); step();
        total++; if (lu_hit_o !== 1'b1 || lu_level_o !== 2'd0 || lu_ppn_o !== 44'h777)
            begin bad++; $display("FAIL lvl3_as_4k_hit: got h=%b l=%0d %h want h=1 l=0 777", lu_hit_o, lu_level_o, lu_ppn_o); end
    endtask

    task automatic test_plru();
        reset_dut();
        for (int i = 0; i < N; i++) begin
            set_fill(14'd7, 29'(32'h100 + i), 44'(32'h900 + i), 4'hF, 2'd0); step();
        end
        for (int i = 0; i < 8; i++) begin
            set_lookup(14'd7, 29'(32'h100 + i)); step();
            total++; if (lu_hit_o !== 1'b1) begin bad++; $display("FAIL plru_warm_%0d: got %b want 1", i, lu_hit_o); end
        end
        step();
        set_fill(14'd7, 29'h200, 44'hBEEF, 4'hF, 2'd0); step();
        set_lookup(14'd7, 29'h200); step();
        total++; if (lu_hit_o !== 1'b1 || lu_ppn_o !== 44'hBEEF)
            begin bad++; $display("FAIL plru_new: got h=%b %h want h=1 beef", lu_hit_o, lu_ppn_o); end
        for (int i = 0; i < N; i++) begin
            set_lookup(14'd7, 29'(32'h100 + i)); step();
            total++; if (lu_hit_o !== exp_hit)
                begin bad++; $display("FAIL plru_keep_%0d: got %b want %b", i, lu_hit_o, exp_hit); end
            if (i < 8) begin
                total++; if (lu_hit_o !== 1'b1) begin bad++; $display("FAIL plru_low_%0d: got %b want 1", i, lu_hit_o); end
            end
        end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            set_fill((i % 2 == 0) ? 14'd3 : 14'd5, 29'(32'h3000 + i), 44'(32'h60 + i), 4'h7, 2'd0); step();
        end
        set_flush(1'b1, 14'd3, 1'b0, '0); set_lookup(14'd5, 29'h3001); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b0)
            begin bad++; $display("FAIL flush_same_cycle_lu: got v=%b h=%b want v=1 h=0", lu_valid_o, lu_hit_o); end
        for (int i = 0; i < 8; i++) begin
            set_lookup((i % 2 == 0) ? 14'd3 : 14'd5, 29'(32'h3000 + i)); step();
            total++; if (lu_hit_o !== exp_hit || lu_hit_o !== 1'(i % 2))
                begin bad++; $display("FAIL flush_vmid_%0d: got %b want %b", i, lu_hit_o, exp_hit); end
        end
        set_flush(1'b1, 14'd9, 1'b0, '0); set_fill(14'd5, 29'h3100, 44'h1, 4'h1, 2'd0); step();
        set_lookup(14'd5, 29'h3100); step();
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL flush_drops_fill: got %b want 0", lu_hit_o); end
        set_fill(14'd5, 29'h40000, 44'h123456, 4'h3, 2'd2); step();
        set_flush(1'b0, '0, 1'b1, 29'h41234); step();
        set_lookup(14'd5, 29'h40000); step();
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL flush_gaddr_1g: got %b want 0", lu_hit_o); end
        set_lookup(14'd5, 29'h3001); step();
        total++; if (lu_hit_o !== 1'b1) begin bad++; $display("FAIL flush_gaddr_keep: got %b want 1", lu_hit_o); end
        set_flush(1'b0, '0, 1'b0, '0); step();
        set_lookup(14'd5, 29'h3003); step();
        total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL flush_all: got %b want 0", lu_hit_o); end
    endtask

    task automatic test_same_cycle();
        reset_dut();
        set_fill(14'd2, 29'h7777, 44'h11, 4'h5, 2'd0); set_lookup(14'd2, 29'h7777); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b0)
            begin bad++; $display("FAIL fill_lu_same: got v=%b h=%b want v=1 h=0", lu_valid_o, lu_hit_o); end
        set_lookup(14'd2, 29'h7777); step();
        total++; if (lu_hit_o !== 1'b1 || lu_ppn_o !== 44'h11)
            begin bad++; $display("FAIL fill_lu_next: got h=%b %h want h=1 11", lu_hit_o, lu_ppn_o); end
        set_fill(14'd2, 29'h7777, 44'h55, 4'h6, 2'd0); step();
        set_lookup(14'd2, 29'h7777); step();
        total++; if (lu_hit_o !== 1'b1 || lu_ppn_o !== 44'h55 || lu_perm_o !== 4'h6)
            begin bad++; $display("FAIL refill: got h=%b %h %h want h=1 55 6", lu_hit_o, lu_ppn_o, lu_perm_o); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_fill(14'd6, 29'h99, 44'h42, 4'h1, 2'd0); step();
        set_lookup(14'd6, 29'h99); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b1)
            begin bad++; $display("FAIL rstmid_pre: got v=%b h=%b want 1 1", lu_valid_o, lu_hit_o); end
        set_lookup(14'd6, 29'h99); rst_i = 1'b1; step();
        total++; if (lu_valid_o !== 1'b0 || lu_hit_o !== 1'b0)
            begin bad++; $display("FAIL rstmid_drop: got v=%b h=%b want 0 0", lu_valid_o, lu_hit_o); end
        set_lookup(14'd6, 29'h99); step();
        total++; if (lu_valid_o !== 1'b1 || lu_hit_o !== 1'b0)
            begin bad++; $display("FAIL rstmid_cleared: got v=%b h=%b want 1 0", lu_valid_o, lu_hit_o); end
    endtask

    function automatic logic [28:0] rand_gppn();
        return 29'(($urandom_range(0, 3) << 18) | ($urandom_range(0, 3) << 9) | $urandom_range(0, 3));
    endfunction

    task automatic test_random();
        int r;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 3) != 0) set_lookup(14'($urandom_range(0, 2)), rand_gppn());
            if (r < 40)
                set_fill(14'($urandom_range(0, 2)), rand_gppn(), 44'({$urandom(), $urandom()}),
                         4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            if (r >= 95)
                set_flush(1'($urandom_range(0, 1)), 14'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), rand_gppn());
            step();
            total++; if (lu_valid_o !== exp_valid)
                begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, lu_valid_o, exp_valid); end
            if (exp_valid) begin
                total++; if (lu_hit_o !== exp_hit)
                    begin bad++; $display("FAIL rnd_hit@%0d: got %b want %b", n, lu_hit_o, exp_hit); end
                if (exp_hit) begin
                    total++; if (lu_ppn_o !== exp_ppn || lu_perm_o !== exp_perm || lu_level_o !== exp_level)
                        begin bad++; $display("FAIL rnd_data@%0d: got %h/%h/%0d want %h/%h/%0d", n,
                            lu_ppn_o, lu_perm_o, lu_level_o, exp_ppn, exp_perm, exp_level); end
                end
            end
        end
    endtask

`ifdef CVA6_GTLB_PERF_CNT_EN
    task automatic test_perf();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            set_fill(14'd8, 29'(32'h500 + i), 44'(i), 4'h1, 2'd0); step();
        end
        for (int i = 0; i < 5; i++) begin
            set_lookup(14'd8, 29'(32'h500 + i)); step();
        end
        step(); step();
        total++; if (perf_hit_cnt_o !== 32'd3 || perf_hit_cnt_o !== 32'(m_phit))
            begin bad++; $display("FAIL perf_hit: got %0d want 3", perf_hit_cnt_o); end
        total++; if (perf_miss_cnt_o !== 32'd2 || perf_miss_cnt_o !== 32'(m_pmiss))
            begin bad++; $display("FAIL perf_miss: got %0d want 2", perf_miss_cnt_o); end
        set_lookup(14'd8, 29'h500); step();
        rst_i = 1'b1; step();
        step();
        total++; if (perf_hit_cnt_o !== 32'd0 || perf_miss_cnt_o !== 32'd0)
            begin bad++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_hit_cnt_o, perf_miss_cnt_o); end
    endtask
`endif

    initial begin
        idle();
        rst_i = 1'b1;
        lu_gppn_i = '0; lu_vmid_i = '0; fill_gppn_i = '0; fill_vmid_i = '0;
        fill_ppn_i = '0; fill_perm_i = '0; fill_level_i = '0; flush_vmid_i = '0; flush_gppn_i = '0;
        test_reset();
        test_basic();
        test_superpage();
        test_plru();
        test_flush();
        test_same_cycle();
        test_reset_mid();
        test_random();
`ifdef CVA6_GTLB_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_gtlb.md
Name: cva6_gtlb

Overview:
- Fully-associative G-stage (guest-physical to host-physical) TLB for the hypervisor-enabled CVA6 MMU.
- Sits downstream of the per-port I/D TLB miss path and upstream of the shared PTW G-stage walk.
- Caches Sv39x4 leaf translations tagged by VMID.
- Provides 1-cycle registered lookup, refill from the PTW, HFENCE.GVMA flush, and tree-PLRU replacement.

Parameters:
- NrEntries, 16, number of entries; must be a power of 2, at least 2.
- VmidWidth, 14, VMID tag width.
- GppnWidth, 29, guest-physical page number width (41-bit GPA).
- PpnWidth, 44, host PPN width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lu_valid_i  in  1  lookup request
- lu_gppn_i  in  GppnWidth  lookup GPPN
- lu_vmid_i  in  VmidWidth  lookup VMID
- lu_valid_o  out  1  response valid, one cycle after lu_valid_i
- lu_hit_o  out  1  hit
- lu_ppn_o  out  PpnWidth  translated PPN, superpage low bits merged in
- lu_perm_o  out  4  {u,x,w,r} of the hit entry
- lu_level_o  out  2  0=4K, 1=2M, 2=1G
- fill_valid_i  in  1  write entry
- fill_gppn_i  in  GppnWidth  fill tag
- fill_vmid_i  in  VmidWidth  fill VMID
- fill_ppn_i  in  PpnWidth  fill PPN
- fill_perm_i  in  4  fill permissions
- fill_level_i  in  2  fill page size
- flush_i  in  1  HFENCE.GVMA
- flush_vmid_en_i  in  1  restrict flush to flush_vmid_i
- flush_vmid_i  in  VmidWidth  VMID to flush
- flush_gaddr_en_i  in  1  restrict flush to flush_gppn_i
- flush_gppn_i  in  GppnWidth  GPPN to flush

Behaviour:
- Reset:
  - All valid bits cleared; PLRU tree bits all 0.
  - lu_valid_o, lu_hit_o = 0; lu_ppn_o, lu_perm_o, lu_level_o = 0.
- Lookup:
  - Match per entry: valid and vmid equal and tag match under a level mask.
  - Level 0 compares all bits; level 1 ignores gppn[8:0]; level 2 ignores gppn[17:0].
  - Compare and one-hot select are combinational; all outputs are registered, giving 1-cycle latency.
  - No backpressure: one lookup is accepted per cycle, and back-to-back lookups are legal.
  - lu_ppn_o: low 9 bits (level 1) or 18 bits (level 2) are taken from the request GPPN.
  - If multiple entries hit (must not happen), the lowest index wins.
- Fill:
  - Takes effect at the clock edge.
  - If an entry with the same vmid, masked tag and level is valid, that entry is overwritten.
  - Otherwise the lowest-index invalid entry is used; if none is invalid, the PLRU victim is used.
- PLRU:
  - Tree of NrEntries-1 bits.
  - Updated on a registered hit and on a fill, pointing away from the touched entry.
  - When a hit and a fill occur in the same cycle, the fill's update is applied last.
- Same-cycle ordering:
  - A lookup in the same cycle as a fill sees pre-fill contents.
  - A lookup in the cycle after a fill sees the new entry.
- Flush:
  - Invalidates entries that match all enabled filters; with both enables low, all entries are invalidated.
  - The gaddr filter uses each entry's level mask.
  - Takes effect at the edge.
  - A fill in the same cycle as flush_i is dropped.
  - A lookup in the same cycle as flush_i returns lu_hit_o = 0 (lu_valid_o still asserted).
- Reset mid-operation: a pending response is discarded (lu_valid_o = 0 the next cycle).
- Illegal fill_level_i = 3 is treated as level 0.

Optional Feature:
- Macro: CVA6_GTLB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_hit_cnt_o [31:0] and perf_miss_cnt_o [31:0].
  - Counters increment on each registered lookup response with hit or miss respectively.
  - Counters saturate at 0xFFFF_FFFF, clear on rst_i, and are not affected by flush.
- When undefined: these ports and counters do not exist.

Decomposition:
- Shared package cva6_gtlb_pkg holds:
  - gtlb_entry_t {valid, vmid, gppn, ppn, perm, level};
  - level localparams LVL_4K, LVL_2M, LVL_1G;
  - function level_mask(level) returning the GPPN compare mask.
- One sub-module: cva6_plru_tree, which takes the NrEntries parameter.
  - Inputs: touch_valid, touch_idx.
  - Output: victim_idx.

Test Plan:
- Reset, fill vmid=3 gppn=0x1000 ppn=0xABCDE level 0, then lookup vmid=3 gppn=0x1000 -> next-cycle hit=1, ppn=0xABCDE; the same lookup with vmid=4 -> hit=0.
- Fill level 1 gppn=0x2_0000 ppn=0x4_0000, lookup gppn=0x2_0123 -> hit, ppn=0x4_0123, level=1.
- Fill 16 distinct entries, then hit entries 0..7, then fill a 17th -> the victim is in 8..15 per the PLRU; entries 0..7 still hit.
- Flush with vmid_en=1, vmid=3 and a mix of vmid 3/5 entries -> all vmid-3 lookups miss, vmid-5 lookups still hit; flush+fill in the same cycle -> the filled tag misses afterwards.
- Lookup and fill of the same tag in the same cycle -> miss; the next-cycle lookup -> hit; refill of an existing tag with new ppn=0x55 -> no duplicate, lookup returns 0x55.
- With CVA6_GTLB_PERF_CNT_EN: 3 hits and 2 misses -> perf_hit_cnt_o=3, perf_miss_cnt_o=2; rst_i mid-stream -> both counters 0.
